// File: rtl/axi4_slave_pkg.sv
// Shared types and helpers for the AXI4-full memory responder.
`timescale 1ns/1ps
package axi4_slave_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_WORD   = 3'b010;

  // Only full-word beats are served; WRAP needs a power-of-two beat count.
  function automatic logic burst_illegal(input logic [2:0] size, input logic [7:0] len,
                                         input logic [1:0] burst);
    logic bad;
    bad = (size != SIZE_WORD) || (burst == 2'b11);
    if (burst == BURST_WRAP)
      bad = bad || !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
    return bad;
  endfunction

endpackage

// File: rtl/axi4_full_slave_mem_if.sv
// AXI4-full bus bundle between a master and the memory responder.
`timescale 1ns/1ps
interface axi4_full_slave_mem_if #(
  parameter int ID_W   = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
`timescale 1ns/1ps
module axi4_burst_addr_gen
  import axi4_slave_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    step      = ADDR_W'(1) << size;
    incr_addr = addr + step;
    // len is 2^n-1 for legal WRAP, so (len << size) | (step-1) is the window mask
    wrap_mask = (ADDR_W'(len) << size) | (step - ADDR_W'(1));
    next_addr = addr;
    case (burst)
      BURST_INCR: next_addr = incr_addr;
      BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:    next_addr = addr;
    endcase
  end
endmodule

// File: rtl/axi4_full_slave_mem.sv
// AXI4-full memory responder: independent write/read FSMs around a byte-enabled
// simple dual-port word RAM, one outstanding burst per direction.
`timescale 1ns/1ps
module axi4_full_slave_mem
  import axi4_slave_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int MEM_WORDS          = 1024
) (
  input logic            ACLK,
  input logic            ARESETN,
  axi4_full_slave_mem_if.slave s_axi
);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Holds the READY outputs low until the first clock after reset release.
  logic alive;

  wstate_t                       w_state, w_state_nx;
  logic [C_S_AXI_ID_WIDTH-1:0]   w_id;
  logic [C_S_AXI_ADDR_WIDTH-1:0] w_addr, w_next;
  logic [7:0]                    w_len;
  logic [2:0]                    w_size;
  logic [1:0]                    w_burst;
  logic [8:0]                    w_cnt;
  logic                          w_bad, w_mis, w_mis_beat, w_we;
  logic [1:0]                    bresp_q;
  logic                          aw_hs, w_hs, b_hs;
  logic [IDX_W-1:0]              w_idx;

  rstate_t                       r_state, r_state_nx;
  logic [C_S_AXI_ID_WIDTH-1:0]   r_id;
  logic [C_S_AXI_ADDR_WIDTH-1:0] r_addr, r_next;
  logic [7:0]                    r_len;
  logic [2:0]                    r_size;
  logic [1:0]                    r_burst;
  logic [7:0]                    r_cnt;
  logic                          r_bad;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_raw;
  logic                          ar_hs, r_hs, rd_en;
  logic [IDX_W-1:0]              rd_idx;

  // Lock/cache/prot/qos carry no meaning for a plain RAM.
  logic unused_sideband;
  assign unused_sideband = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos,
                             s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) alive <= 1'b0;
    else          alive <= 1'b1;
  end

  axi4_burst_addr_gen #(.ADDR_W(C_S_AXI_ADDR_WIDTH)) u_w_addr_gen (
    .addr(w_addr), .len(w_len), .size(w_size), .burst(w_burst), .next_addr(w_next)
  );

  axi4_burst_addr_gen #(.ADDR_W(C_S_AXI_ADDR_WIDTH)) u_r_addr_gen (
    .addr(r_addr), .len(r_len), .size(r_size), .burst(r_burst), .next_addr(r_next)
  );

  // ---- write channel ----
  always_comb begin
    w_state_nx    = w_state;
    s_axi.awready = alive && (w_state == W_IDLE);
    s_axi.wready  = (w_state == W_DATA);
    s_axi.bvalid  = (w_state == W_RESP);
    aw_hs         = s_axi.awvalid && s_axi.awready;
    w_hs          = s_axi.wvalid && s_axi.wready;
    b_hs          = s_axi.bvalid && s_axi.bready;
    w_mis_beat    = w_hs && (s_axi.wlast != (w_cnt == {1'b0, w_len}));
    w_we          = w_hs && !w_bad && (w_cnt <= {1'b0, w_len});
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nx = W_DATA;
      W_DATA:  if (w_hs && s_axi.wlast) w_state_nx = W_RESP;
      W_RESP:  if (b_hs) w_state_nx = W_IDLE;
      default: w_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_cnt   <= '0;
      w_bad   <= 1'b0;
      w_mis   <= 1'b0;
      bresp_q <= RESP_OKAY;
    end else begin
      w_state <= w_state_nx;
      if (aw_hs) begin
        w_id  <= s_axi.awid;
        w_cnt <= '0;
        w_bad <= burst_illegal(s_axi.awsize, s_axi.awlen, s_axi.awburst);
        w_mis <= 1'b0;
      end
      if (w_hs) begin
        if (w_cnt != '1) w_cnt <= w_cnt + 9'd1;
        if (w_mis_beat)  w_mis <= 1'b1;
        if (s_axi.wlast)
          bresp_q <= (w_bad || w_mis || w_mis_beat) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (aw_hs) begin
      w_addr  <= s_axi.awaddr;
      w_len   <= s_axi.awlen;
      w_size  <= s_axi.awsize;
      w_burst <= s_axi.awburst;
    end else if (w_hs) begin
      w_addr <= w_next;
    end
  end

  assign s_axi.bid   = w_id;
  assign s_axi.bresp = bresp_q;
  assign w_idx       = w_addr[IDX_W+1:2];

  // ---- read channel ----
  always_comb begin
    r_state_nx    = r_state;
    s_axi.arready = alive && (r_state == R_IDLE);
    s_axi.rvalid  = (r_state == R_DATA);
    s_axi.rlast   = (r_state == R_DATA) && (r_cnt == r_len);
    s_axi.rresp   = ((r_state == R_DATA) && r_bad) ? RESP_SLVERR : RESP_OKAY;
    s_axi.rdata   = ((r_state == R_DATA) && !r_bad) ? rdata_raw : '0;
    s_axi.rid     = r_id;
    ar_hs         = s_axi.arvalid && s_axi.arready;
    r_hs          = s_axi.rvalid && s_axi.rready;
    // Prefetch the next beat's word as each beat is accepted.
    rd_en         = ar_hs || (r_hs && !s_axi.rlast);
    rd_idx        = (r_state == R_IDLE) ? s_axi.araddr[IDX_W+1:2] : r_next[IDX_W+1:2];
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nx = R_DATA;
      R_DATA:  if (r_hs && s_axi.rlast) r_state_nx = R_IDLE;
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_cnt   <= '0;
      r_bad   <= 1'b0;
    end else begin
      r_state <= r_state_nx;
      if (ar_hs) begin
        r_id  <= s_axi.arid;
        r_cnt <= '0;
        r_bad <= burst_illegal(s_axi.arsize, s_axi.arlen, s_axi.arburst);
      end else if (r_hs) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ar_hs) begin
      r_addr  <= s_axi.araddr;
      r_len   <= s_axi.arlen;
      r_size  <= s_axi.arsize;
      r_burst <= s_axi.arburst;
    end else if (r_hs) begin
      r_addr <= r_next;
    end
  end

  // ---- RAM: one byte-enabled write port, one registered read port ----
  always_ff @(posedge ACLK) begin
    if (w_we) begin
      for (int b = 0; b < STRB_W; b++)
        if (s_axi.wstrb[b]) mem[w_idx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
    end
    if (rd_en) rdata_raw <= mem[rd_idx];
  end

endmodule

// File: tb/tb_axi4_full_slave_mem.sv
// Directed bench for axi4_full_slave_mem: bursts, wrap order, strobes, backpressure, errors.
`timescale 1ns/1ps
module tb_axi4_full_slave_mem;
  import axi4_slave_pkg::*;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 aclk = ~aclk;

  axi4_full_slave_mem_if #(.ID_W(1), .ADDR_W(32), .DATA_W(32)) bus();

  axi4_full_slave_mem #(
    .C_S_AXI_ID_WIDTH(1), .C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32), .MEM_WORDS(1024)
  ) dut (
    .ACLK(aclk), .ARESETN(aresetn), .s_axi(bus)
  );

  logic [31:0] wbuf    [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [1:0]  bresp_got;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] strb, input int last_idx,
                           input int bdelay, output logic [1:0] resp);
    int n;
    resp = 2'b11;
    @(negedge aclk);
    bus.awid = 1'b1; bus.awaddr = addr; bus.awlen = len; bus.awsize = size;
    bus.awburst = burst; bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) chk("aw_timeout", 32'(n), 32'd0);
    @(negedge aclk);
    bus.awvalid = 1'b0;
    for (int i = 0; i <= last_idx; i++) begin
      bus.wdata = wbuf[i]; bus.wstrb = strb; bus.wlast = (i == last_idx); bus.wvalid = 1'b1;
      n = 0;
      while (!bus.wready && n < 50) begin @(negedge aclk); n++; end
      if (n >= 50) chk("w_timeout", 32'(n), 32'd0);
      @(negedge aclk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) chk("b_timeout", 32'(n), 32'd0);
    for (int k = 0; k < bdelay; k++) begin
      @(negedge aclk);
      chk("bvalid_held", 32'(bus.bvalid), 32'd1);
    end
    resp = bus.bresp;
    chk("bid", 32'(bus.bid), 32'd1);
    bus.bready = 1'b1;
    @(negedge aclk);
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input bit toggle);
    int n, beats, cyc;
    logic [31:0] held;
    bit held_v;
    @(negedge aclk);
    bus.arid = 1'b1; bus.araddr = addr; bus.arlen = len; bus.arsize = size;
    bus.arburst = burst; bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) chk("ar_timeout", 32'(n), 32'd0);
    @(negedge aclk);
    bus.arvalid = 1'b0;
    chk("rvalid_latency", 32'(bus.rvalid), 32'd1);
    chk("rid", 32'(bus.rid), 32'd1);
    beats = 0; cyc = 0; held_v = 0; held = '0;
    while (beats <= int'(len) && cyc < 200) begin
      if (held_v) chk("rdata_stable", bus.rdata, held);
      bus.rready = toggle ? (cyc % 2 == 1) : 1'b1;
      held_v = 0;
      if (bus.rvalid && bus.rready) begin
        rd_data[beats] = bus.rdata; rd_resp[beats] = bus.rresp; rd_last[beats] = bus.rlast;
        beats++;
      end else if (bus.rvalid) begin
        held = bus.rdata; held_v = 1;
      end
      @(negedge aclk);
      cyc++;
    end
    bus.rready = 1'b0;
    if (beats <= int'(len)) chk("r_timeout", 32'(beats), 32'(len) + 32'd1);
  endtask

  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awqos = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arqos = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    // Reset held for 200 ns
    aresetn = 1'b0;
    #100;
    chk("rst_awready", 32'(bus.awready), 32'd0);
    chk("rst_arready", 32'(bus.arready), 32'd0);
    chk("rst_wready",  32'(bus.wready),  32'd0);
    chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
    chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
    chk("rst_rlast",   32'(bus.rlast),   32'd0);
    chk("rst_bresp",   32'(bus.bresp),   32'd0);
    chk("rst_rdata",   bus.rdata,        32'd0);
    #100;
    aresetn = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    chk("post_rst_awready", 32'(bus.awready), 32'd1);
    chk("post_rst_arready", 32'(bus.arready), 32'd1);

    // INCR write then read back
    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
    axi_write(32'h40, 8'd3, 3'b010, 2'b01, 4'hF, 3, 0, bresp_got);
    chk("incr_bresp", 32'(bresp_got), 32'd0);
    axi_read(32'h40, 8'd3, 3'b010, 2'b01, 1'b0);
    chk("incr_rd0", rd_data[0], 32'h11);
    chk("incr_rd1", rd_data[1], 32'h22);
    chk("incr_rd2", rd_data[2], 32'h33);
    chk("incr_rd3", rd_data[3], 32'h44);
    chk("incr_rlast0", 32'(rd_last[0]), 32'd0);
    chk("incr_rlast2", 32'(rd_last[2]), 32'd0);
    chk("incr_rlast3", 32'(rd_last[3]), 32'd1);
    chk("incr_rresp", 32'(rd_resp[0]), 32'd0);

    // WRAP read from 0x48 over the 16-byte window at 0x40
    axi_read(32'h48, 8'd3, 3'b010, 2'b10, 1'b0);
    chk("wrap_rd0", rd_data[0], 32'h33);
    chk("wrap_rd1", rd_data[1], 32'h44);
    chk("wrap_rd2", rd_data[2], 32'h11);
    chk("wrap_rd3", rd_data[3], 32'h22);
    chk("wrap_rlast3", 32'(rd_last[3]), 32'd1);

    // Partial strobe merge
    wbuf[0] = 32'hFFFF_FFFF;
    axi_write(32'h80, 8'd0, 3'b010, 2'b01, 4'hF, 0, 0, bresp_got);
    wbuf[0] = 32'hAABB_CCDD;
    axi_write(32'h80, 8'd0, 3'b010, 2'b01, 4'b0101, 0, 0, bresp_got);
    chk("strb_bresp", 32'(bresp_got), 32'd0);
    axi_read(32'h80, 8'd0, 3'b010, 2'b01, 1'b0);
    chk("strb_rd", rd_data[0], 32'hFFBB_FFDD);
    chk("strb_rlast", 32'(rd_last[0]), 32'd1);

    // Backpressure: RREADY toggling, BREADY delayed 5 cycles
    axi_read(32'h40, 8'd3, 3'b010, 2'b01, 1'b1);
    chk("bp_rd0", rd_data[0], 32'h11);
    chk("bp_rd1", rd_data[1], 32'h22);
    chk("bp_rd2", rd_data[2], 32'h33);
    chk("bp_rd3", rd_data[3], 32'h44);
    chk("bp_rlast3", 32'(rd_last[3]), 32'd1);
    wbuf[0] = 32'h1234_5678;
    axi_write(32'h84, 8'd0, 3'b010, 2'b01, 4'hF, 0, 5, bresp_got);
    chk("bp_bresp", 32'(bresp_got), 32'd0);

    // Illegal AWSIZE: SLVERR and no write
    wbuf[0] = 32'hDEAD_BEEF;
    axi_write(32'h40, 8'd0, 3'b001, 2'b01, 4'hF, 0, 0, bresp_got);
    chk("size_err_bresp", 32'(bresp_got), 32'd2);
    axi_read(32'h40, 8'd0, 3'b010, 2'b01, 1'b0);
    chk("size_err_mem", rd_data[0], 32'h11);

    // Early WLAST on beat 2 of a 4-beat burst
    wbuf[0] = 32'h55; wbuf[1] = 32'h66;
    axi_write(32'h100, 8'd3, 3'b010, 2'b01, 4'hF, 1, 0, bresp_got);
    chk("early_wlast_bresp", 32'(bresp_got), 32'd2);

    // Reserved burst type on read: SLVERR, zero data, correct RLAST
    axi_read(32'h40, 8'd1, 3'b010, 2'b11, 1'b0);
    chk("rd_err_resp0", 32'(rd_resp[0]), 32'd2);
    chk("rd_err_resp1", 32'(rd_resp[1]), 32'd2);
    chk("rd_err_data0", rd_data[0], 32'd0);
    chk("rd_err_rlast0", 32'(rd_last[0]), 32'd0);
    chk("rd_err_rlast1", 32'(rd_last[1]), 32'd1);

    // Recovery after errors
    axi_read(32'h44, 8'd0, 3'b010, 2'b01, 1'b0);
    chk("recover_rd", rd_data[0], 32'h22);
    chk("recover_rresp", 32'(rd_resp[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
